// File: rtl/counter_unit_if.sv
// Bus-side register interface of the counter unit: write strobe, target
// select, write data and the combinational read-back.
interface counter_unit_if;
    logic        counter_we;
    logic [1:0]  counter_set;
    logic [31:0] Peripheral_in;
    logic [31:0] counter_out;

    // Bus decoder / CPU side drives the write, samples the read data.
    modport master (
        output counter_we,
        output counter_set,
        output Peripheral_in,
        input  counter_out
    );

    // Counter unit side.
    modport slave (
        input  counter_we,
        input  counter_set,
        input  Peripheral_in,
        output counter_out
    );
endinterface

// File: rtl/counter_unit.sv
// Three-channel down-counter/timer with a shared 8-bit prescaler.
// Each channel runs one-shot (status latches high at terminal count) or
// periodic (reloads and toggles status at terminal count).
module counter_unit (
    input  logic           clk,
    input  logic           rst,
    counter_unit_if.slave  bus,
    output logic           counter0_out,
    output logic           counter1_out,
    output logic           counter2_out
);

    logic [31:0] r_count  [3];
    logic [31:0] r_reload [3];
    logic [2:0]  r_out;
    logic [2:0]  r_en;
    logic [2:0]  r_mode;
    logic [7:0]  r_psc_lim;
    logic [7:0]  r_psc;

    logic        w_ctrl_wr;
    logic [2:0]  w_ch_wr;
    logic        w_tick_raw;
    logic        w_tick;
    logic [31:0] w_ctrl_rd;

    // Decode the write target and the prescaler tick; a control write
    // restarts the prescaler, so a tick landing on that edge is dropped.
    always_comb begin
        w_ctrl_wr  = bus.counter_we && (bus.counter_set == 2'd3);
        for (int n = 0; n < 3; n++) begin
            w_ch_wr[n] = bus.counter_we && (bus.counter_set == 2'(n));
        end
        w_tick_raw = (r_psc == r_psc_lim);
        w_tick     = w_tick_raw && !w_ctrl_wr;
        w_ctrl_rd  = {16'd0, r_psc_lim, 1'b0, r_mode, 1'b0, r_en};
    end

    // Prescaler and control register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_psc     <= 8'd0;
            r_psc_lim <= 8'd0;
            r_en      <= 3'd0;
            r_mode    <= 3'd0;
        end else if (w_ctrl_wr) begin
            r_psc     <= 8'd0;
            r_psc_lim <= bus.Peripheral_in[15:8];
            r_en      <= bus.Peripheral_in[2:0];
            r_mode    <= bus.Peripheral_in[6:4];
        end else if (w_tick_raw) begin
            r_psc     <= 8'd0;
        end else begin
            r_psc     <= r_psc + 8'd1;
        end
    end

    // Per-channel count, reload and status; a channel write beats a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                r_count[n]  <= 32'd0;
                r_reload[n] <= 32'd0;
            end
            r_out <= 3'd0;
        end else begin
            for (int n = 0; n < 3; n++) begin
                if (w_ch_wr[n]) begin
                    r_count[n]  <= bus.Peripheral_in;
                    r_reload[n] <= bus.Peripheral_in;
                    r_out[n]    <= 1'b0;
                end else if (w_tick && r_en[n]) begin
                    if (r_count[n] > 32'd1) begin
                        r_count[n] <= r_count[n] - 32'd1;
                    end else if (r_count[n] == 32'd1) begin
                        if (r_mode[n]) begin
                            r_count[n] <= r_reload[n];
                            r_out[n]   <= ~r_out[n];
                        end else begin
                            r_count[n] <= 32'd0;
                            r_out[n]   <= 1'b1;
                        end
                    end
                    // count == 0: hold, no status change
                end
            end
        end
    end

    // Combinational read-back of the selected register.
    always_comb begin
        case (bus.counter_set)
            2'd0:    bus.counter_out = r_count[0];
            2'd1:    bus.counter_out = r_count[1];
            2'd2:    bus.counter_out = r_count[2];
            default: bus.counter_out = w_ctrl_rd;
        endcase
    end

    assign counter0_out = r_out[0];
    assign counter1_out = r_out[1];
    assign counter2_out = r_out[2];

endmodule

// File: tb/tb_counter_unit.sv
// Scoreboard bench for counter_unit: every driven cycle pushes the
// expected read-back and status from a behavioural model; a monitor pops
// and compares on each falling edge. Directed scenarios add fixed checks.
module tb_counter_unit;

    logic clk = 1'b0;
    logic rst;
    logic c0, c1, c2;

    always #5 clk = ~clk;

    counter_unit_if bus ();

    counter_unit dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .counter0_out (c0),
        .counter1_out (c1),
        .counter2_out (c2)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic [2:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Behavioural model state
    logic [31:0] m_count  [3];
    logic [31:0] m_reload [3];
    bit   [2:0]  m_out;
    bit   [2:0]  m_en;
    bit   [2:0]  m_mode;
    int unsigned m_p;
    int unsigned m_psc;

    // Inputs sampled by the next rising edge
    bit          p_rst;
    bit          p_we;
    bit   [1:0]  p_set;
    logic [31:0] p_data;

    // Advance the model over one rising edge using the pending inputs.
    function automatic void model_step();
        bit tick;
        if (p_rst) begin
            for (int n = 0; n < 3; n++) begin
                m_count[n]  = 0;
                m_reload[n] = 0;
            end
            m_out = 0; m_en = 0; m_mode = 0; m_p = 0; m_psc = 0;
            return;
        end
        tick = (m_psc == m_p);
        if (p_we && p_set == 3) begin
            m_en   = p_data[2:0];
            m_mode = p_data[6:4];
            m_p    = p_data[15:8];
            m_psc  = 0;
            tick   = 0;
        end else begin
            m_psc = tick ? 0 : m_psc + 1;
        end
        for (int n = 0; n < 3; n++) begin
            if (p_we && p_set == n) begin
                m_count[n]  = p_data;
                m_reload[n] = p_data;
                m_out[n]    = 0;
            end else if (tick && m_en[n]) begin
                if (m_count[n] > 1) begin
                    m_count[n] = m_count[n] - 1;
                end else if (m_count[n] == 1) begin
                    if (m_mode[n]) begin
                        m_count[n] = m_reload[n];
                        m_out[n]   = !m_out[n];
                    end else begin
                        m_count[n] = 0;
                        m_out[n]   = 1;
                    end
                end
            end
        end
    endfunction

    function automatic logic [31:0] model_read(input bit [1:0] set);
        if (set < 3) return m_count[set];
        return (m_p << 8) + (32'(m_mode) << 4) + 32'(m_en);
    endfunction

    // One bus cycle: settle the model over the edge just taken, drive new
    // inputs and queue the response the DUT must show during this cycle.
    task automatic cycle(input bit r, input bit we, input bit [1:0] set,
                         input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        model_step();
        rst               = r;
        bus.counter_we    = we;
        bus.counter_set   = set;
        bus.Peripheral_in = d;
        p_rst = r; p_we = we; p_set = set; p_data = d;
        e.rd = model_read(set);
        e.st = m_out;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    // Idle cycle reading `set`, then a fixed check of read data and one status bit.
    task automatic idle_chk(input string nm, input bit [1:0] set, input logic [31:0] rd,
                            input int idx, input bit st);
        logic [2:0] stv;
        cycle(0, 0, set, 32'd0);
        @(negedge clk);
        stv = {c2, c1, c0};
        chk({nm, "_rd"}, bus.counter_out, rd);
        chk({nm, "_st"}, 32'(stv[idx]), 32'(st));
    endtask

    // Monitor: compare the queued expectation against the DUT each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.counter_out !== e.rd) begin
                    bad++;
                    $display("FAIL sb_rd: got %h want %h set=%0d at %0t",
                             bus.counter_out, e.rd, bus.counter_set, $time);
                end
                total++;
                if ({c2, c1, c0} !== e.st) begin
                    bad++;
                    $display("FAIL sb_status: got %b want %b at %0t", {c2, c1, c0}, e.st, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        bit   [1:0]  s;
        rst = 1'b1;
        bus.counter_we = 1'b0;
        bus.counter_set = 2'd0;
        bus.Peripheral_in = 32'd0;
        p_rst = 1; p_we = 0; p_set = 0; p_data = 0;

        cycle(1, 0, 0, 0);
        cycle(0, 0, 3, 0);

        // One-shot ch0 = 5 at P=0
        cycle(0, 1, 3, 32'h1);
        cycle(0, 1, 0, 32'd5);
        for (int i = 0; i <= 5; i++) idle_chk("oneshot", 0, 32'(5 - i), 0, i == 5);
        for (int i = 0; i < 20; i++) idle_chk("oneshot_hold", 0, 0, 0, 1);

        // Periodic ch1 = 3
        cycle(0, 1, 3, 32'h22);
        cycle(0, 1, 1, 32'd3);
        for (int i = 0; i < 10; i++) idle_chk("periodic", 1, 32'(3 - i % 3), 1, ((i / 3) % 2) == 1);

        // Prescaler P=3, ch2 one-shot = 2
        cycle(0, 1, 3, 32'h304);
        cycle(0, 1, 2, 32'd2);
        for (int i = 1; i <= 8; i++)
            idle_chk("prescale", 2, (i < 4) ? 32'd2 : ((i < 8) ? 32'd1 : 32'd0), 2, i == 8);

        // Write collides with terminal tick
        cycle(0, 1, 3, 32'h1);
        cycle(0, 1, 0, 32'd2);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 32'd7);
        idle_chk("collision", 0, 32'd7, 0, 0);

        // Reset in the middle of a periodic count
        cycle(0, 1, 3, 32'h22);
        cycle(0, 1, 1, 32'd10);
        repeat (6) cycle(0, 0, 1, 0);
        idle_chk("rmc_cnt", 1, 32'd4, 1, 0);
        cycle(1, 0, 1, 0);
        for (int i = 0; i < 30; i++) idle_chk("rmc_zero", 2'(i % 4), 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s = 2'($urandom_range(0, 3));
            if (s == 3) begin
                d = $urandom;
                if ($urandom_range(0, 3) != 0) d[15:10] = 6'd0;
            end else begin
                d = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 8));
            end
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, s, d);
        end

        // Reset from arbitrary state
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 2'(i), 0);
            @(negedge clk);
            chk("reset_rd", bus.counter_out, 32'd0);
            chk("reset_st", 32'({c2, c1, c0}), 32'd0);
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
